// File: rtl/dpwm_pkg.sv
// Shared geometry and FSM encoding for the DPWM voltage-loop compensator.
// Derived widths keep the datapath at full precision end to end.
package dpwm_pkg;

   localparam int RESOLUTION = 12;
   localparam int ADC_W      = 10;
   localparam int COEF_W     = 16;
   localparam int FRAC       = 8;

   localparam int ERR_W  = ADC_W + 1;
   localparam int PROD_W = ERR_W + COEF_W;
   localparam int ACC_W  = PROD_W + 3;
   localparam int U_W    = RESOLUTION + FRAC;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MAC0,
      ST_MAC1,
      ST_MAC2,
      ST_SAT,
      ST_OUT
   } state_e;

endpackage

// File: rtl/dpwm_pid_compensator_if.sv
// Sample-in / duty-out bundle between the loop controller and the compensator.
// master drives the sample, setpoint, taps and clamps; slave returns the duty.
interface dpwm_pid_compensator_if;
   import dpwm_pkg::*;

   logic                     enable;
   logic                     sample_valid;
   logic        [ADC_W-1:0]  adc_sample;
   logic        [ADC_W-1:0]  vref;
   logic signed [COEF_W-1:0] coef_a;
   logic signed [COEF_W-1:0] coef_b;
   logic signed [COEF_W-1:0] coef_c;
   logic [RESOLUTION-1:0]    dc_min;
   logic [RESOLUTION-1:0]    dc_max;
   logic [RESOLUTION-1:0]    duty_cycle;
   logic                     duty_valid;
   logic                     busy;
   logic                     overrun;

   modport master (
      output enable, sample_valid, adc_sample, vref, coef_a, coef_b, coef_c, dc_min, dc_max,
      input  duty_cycle, duty_valid, busy, overrun
   );

   modport slave (
      input  enable, sample_valid, adc_sample, vref, coef_a, coef_b, coef_c, dc_min, dc_max,
      output duty_cycle, duty_valid, busy, overrun
   );

endinterface

// File: rtl/dpwm_sat_clamp.sv
// Clamps a signed Q.FRAC accumulator into [dc_min, dc_max] << FRAC.
// When the bounds cross, dc_max wins so the duty never exceeds the upper limit.
module dpwm_sat_clamp #(
   parameter int ACC_W      = 30,
   parameter int RESOLUTION = 12,
   parameter int FRAC       = 8
) (
   input  logic signed [ACC_W-1:0]           acc,
   input  logic        [RESOLUTION-1:0]      dc_min,
   input  logic        [RESOLUTION-1:0]      dc_max,
   output logic        [RESOLUTION+FRAC-1:0] u_sat
);

   localparam int U_W = RESOLUTION + FRAC;

   logic signed [ACC_W-1:0] lo;
   logic signed [ACC_W-1:0] hi;

   always_comb begin
      lo = $signed({{(ACC_W-U_W){1'b0}}, dc_min, {FRAC{1'b0}}});
      hi = $signed({{(ACC_W-U_W){1'b0}}, dc_max, {FRAC{1'b0}}});
      if (acc > hi || lo > hi) begin
         u_sat = {dc_max, {FRAC{1'b0}}};
      end else if (acc < lo) begin
         u_sat = {dc_min, {FRAC{1'b0}}};
      end else begin
         u_sat = acc[U_W-1:0];
      end
   end

endmodule

// File: rtl/dpwm_pid_compensator.sv
// Incremental three-tap PID feeding the DPWM duty_cycle, one shared multiplier,
// six-cycle schedule IDLE->MAC0->MAC1->MAC2->SAT->OUT with clamp-based anti-windup.
module dpwm_pid_compensator
   import dpwm_pkg::*;
(
   input  logic                  hf_clock,
   input  logic                  reset,
   dpwm_pid_compensator_if.slave bus
);

   logic [1:0] rst_sync_q;
   logic [1:0] rst_sync_d;
   logic       rst_n;

   state_e state_q, state_d;

   logic signed [ERR_W-1:0]  e0_q, e0_d, e1_q, e1_d, e2_q, e2_d;
   logic signed [ERR_W-1:0]  err_sel, e_new;
   logic signed [COEF_W-1:0] coef_sel;
   logic signed [PROD_W-1:0] prod;
   logic signed [ACC_W-1:0]  acc_q, acc_d, acc_base;
   logic [U_W-1:0]           u_prev_q, u_prev_d, u_sat;
   logic [RESOLUTION-1:0]    duty_q, duty_d;
   logic                     duty_valid_q, duty_valid_d;
   logic                     overrun_q, overrun_d;

   // Reset asserts immediately but releases two edges later, so no flop sees a runt deassertion.
   assign rst_sync_d = {rst_sync_q[0], 1'b1};

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge hf_clock or negedge reset) begin
      if (!reset) rst_sync_q <= '0;
      else        rst_sync_q <= rst_sync_d;
   end

   assign rst_n = rst_sync_q[1];

   always_ff @(posedge hf_clock or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // NOTE: every always_comb output gets a default first, otherwise unlisted paths infer latches.
   always_comb begin
      state_d = state_q;
      if (!bus.enable) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: if (bus.sample_valid) state_d = ST_MAC0;
            ST_MAC0: state_d = ST_MAC1;
            ST_MAC1: state_d = ST_MAC2;
            ST_MAC2: state_d = ST_SAT;
            ST_SAT:  state_d = ST_OUT;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // The single multiplier walks the taps: a*e0, b*e1, c*e2.
   always_comb begin
      coef_sel = bus.coef_a;
      err_sel  = e0_q;
      case (state_q)
         ST_MAC1: begin coef_sel = bus.coef_b; err_sel = e1_q; end
         ST_MAC2: begin coef_sel = bus.coef_c; err_sel = e2_q; end
         default: ;
      endcase
      prod     = PROD_W'(coef_sel) * PROD_W'(err_sel);
      acc_base = (state_q == ST_MAC0) ? ACC_W'($signed({1'b0, u_prev_q})) : acc_q;
      e_new    = $signed({1'b0, bus.vref}) - $signed({1'b0, bus.adc_sample});
   end

   dpwm_sat_clamp #(
      .ACC_W      (ACC_W),
      .RESOLUTION (RESOLUTION),
      .FRAC       (FRAC)
   ) u_clamp (
      .acc    (acc_q),
      .dc_min (bus.dc_min),
      .dc_max (bus.dc_max),
      .u_sat  (u_sat)
   );

   always_comb begin
      e0_d         = e0_q;
      e1_d         = e1_q;
      e2_d         = e2_q;
      acc_d        = acc_q;
      u_prev_d     = u_prev_q;
      duty_d       = duty_q;
      duty_valid_d = 1'b0;
      overrun_d    = overrun_q;
      if (!bus.enable) begin
         e1_d     = '0;
         e2_d     = '0;
         u_prev_d = '0;
         duty_d   = bus.dc_min;
      end else begin
         if (bus.sample_valid && state_q != ST_IDLE) overrun_d = 1'b1;
         case (state_q)
            ST_IDLE: if (bus.sample_valid) e0_d = e_new;
            ST_MAC0, ST_MAC1, ST_MAC2: acc_d = acc_base + ACC_W'(prod);
            ST_SAT: begin
               u_prev_d = u_sat;
               e2_d     = e1_q;
               e1_d     = e0_q;
            end
            ST_OUT: begin
               duty_d       = u_prev_q[U_W-1:FRAC];
               duty_valid_d = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge hf_clock or negedge rst_n) begin
      if (!rst_n) begin
         e0_q         <= '0;
         e1_q         <= '0;
         e2_q         <= '0;
         acc_q        <= '0;
         u_prev_q     <= '0;
         duty_q       <= '0;
         duty_valid_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         e0_q         <= e0_d;
         e1_q         <= e1_d;
         e2_q         <= e2_d;
         acc_q        <= acc_d;
         u_prev_q     <= u_prev_d;
         duty_q       <= duty_d;
         duty_valid_q <= duty_valid_d;
         overrun_q    <= overrun_d;
      end
   end

   assign bus.duty_cycle = duty_q;
   assign bus.duty_valid = duty_valid_q;
   assign bus.busy       = (state_q != ST_IDLE);
   assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_dpwm_pid_compensator.sv
// Scenario bench for dpwm_pid_compensator against an arithmetic PID reference
// (integers, Q.8 scaling, clamp with dc_max priority).
module tb_dpwm_pid_compensator;

   logic hf_clock;
   logic reset;

   dpwm_pid_compensator_if bus ();

   dpwm_pid_compensator dut (
      .hf_clock (hf_clock),
      .reset    (reset),
      .bus      (bus)
   );

   initial hf_clock = 1'b0;
   always #5 hf_clock = ~hf_clock;

   int n_vec = 0;
   int n_err = 0;

   // Reference state: u in Q.8, error history, current taps and clamps.
   longint m_u;
   int     m_e1, m_e2;
   int     ca, cb, cc, dmin, dmax;

   task automatic model_clear();
      m_u  = 0;
      m_e1 = 0;
      m_e2 = 0;
   endtask

   task automatic model_step(input int e, output int duty);
      longint acc, lo, hi;
      acc = m_u + longint'(ca) * e + longint'(cb) * m_e1 + longint'(cc) * m_e2;
      lo  = longint'(dmin) * 256;
      hi  = longint'(dmax) * 256;
      if (acc < lo) acc = lo;
      if (acc > hi) acc = hi;
      m_u  = acc;
      m_e2 = m_e1;
      m_e1 = e;
      duty = int'(acc / 256);
   endtask

   task automatic set_params(input int a, input int b, input int c, input int mn, input int mx);
      ca = a; cb = b; cc = c; dmin = mn; dmax = mx;
      bus.coef_a = 16'(a);
      bus.coef_b = 16'(b);
      bus.coef_c = 16'(c);
      bus.dc_min = 12'(mn);
      bus.dc_max = 12'(mx);
   endtask

   task automatic clear_history();
      @(negedge hf_clock);
      bus.enable = 1'b0;
      @(negedge hf_clock);
      bus.enable = 1'b1;
      model_clear();
   endtask

   // One strobe, then wait (bounded) for the duty pulse and check latency, value, width.
   task automatic run_sample(input int vref_v, input int adc_v, input string tag);
      int lat;
      int exp_duty;
      model_step(vref_v - adc_v, exp_duty);
      @(negedge hf_clock);
      bus.vref         = vref_v[9:0];
      bus.adc_sample   = adc_v[9:0];
      bus.sample_valid = 1'b1;
      @(posedge hf_clock);
      #1 bus.sample_valid = 1'b0;
      lat = 0;
      do begin
         @(posedge hf_clock);
         #1 lat++;
      end while (!bus.duty_valid && lat < 10);
      n_vec++;
      if (lat !== 5) begin
         n_err++;
         $display("FAIL %s latency: got %0d edges, want 5", tag, lat);
      end
      n_vec++;
      if (bus.duty_cycle !== exp_duty[11:0]) begin
         n_err++;
         $display("FAIL %s duty: got %0d, want %0d", tag, bus.duty_cycle, exp_duty);
      end
      @(posedge hf_clock);
      #1;
      n_vec++;
      if (bus.duty_valid !== 1'b0) begin
         n_err++;
         $display("FAIL %s pulse_width: duty_valid still %b one edge later, want 0", tag, bus.duty_valid);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) @(posedge hf_clock);
      #1;
      n_vec++;
      if ({bus.duty_cycle, bus.duty_valid, bus.busy, bus.overrun} !== 15'd0) begin
         n_err++;
         $display("FAIL reset_hold: got duty=%0d valid=%b busy=%b ovr=%b, want all 0",
                  bus.duty_cycle, bus.duty_valid, bus.busy, bus.overrun);
      end
      @(negedge hf_clock);
      reset = 1'b1;
      repeat (4) @(posedge hf_clock);
      #1;
      n_vec++;
      if ({bus.duty_cycle, bus.duty_valid, bus.busy, bus.overrun} !== 15'd0) begin
         n_err++;
         $display("FAIL reset_release: got duty=%0d valid=%b busy=%b ovr=%b, want all 0",
                  bus.duty_cycle, bus.duty_valid, bus.busy, bus.overrun);
      end
      model_clear();
   endtask

   task automatic test_integrator();
      set_params(256, 0, 0, 0, 4095);
      for (int i = 0; i < 3; i++) begin
         run_sample(512, 500, $sformatf("integrator_%0d", i));
         repeat (13) @(posedge hf_clock);
      end
   endtask

   task automatic test_delayed_tap();
      set_params(0, 256, 0, 0, 4095);
      clear_history();
      run_sample(512, 502, "delayed_tap_0");
      run_sample(512, 512, "delayed_tap_1");
      run_sample(512, 512, "delayed_tap_2");
   endtask

   task automatic test_saturation();
      set_params(256, 0, 0, 0, 2000);
      clear_history();
      for (int i = 0; i < 4; i++) run_sample(1023, 0, $sformatf("sat_up_%0d", i));
      run_sample(0, 1023, "sat_unwind");
   endtask

   task automatic test_overrun();
      int pulses, got, at_edge, exp_duty;
      set_params(256, 0, 0, 0, 4095);
      clear_history();
      #1;
      n_vec++;
      if (bus.overrun !== 1'b0) begin
         n_err++;
         $display("FAIL overrun_pre: got %b, want 0", bus.overrun);
      end
      model_step(5, exp_duty);
      @(negedge hf_clock);
      bus.vref = 10'd512; bus.adc_sample = 10'd507; bus.sample_valid = 1'b1;
      @(posedge hf_clock);
      #1 bus.sample_valid = 1'b0;
      @(posedge hf_clock);
      @(negedge hf_clock);
      bus.adc_sample = 10'd400; bus.sample_valid = 1'b1;
      @(posedge hf_clock);
      #1 bus.sample_valid = 1'b0;
      bus.adc_sample = 10'd507;
      pulses = 0; got = 0; at_edge = 0;
      for (int i = 3; i <= 12; i++) begin
         @(posedge hf_clock);
         #1;
         if (bus.duty_valid) begin
            pulses++;
            got     = int'(bus.duty_cycle);
            at_edge = i;
         end
      end
      n_vec++;
      if (pulses !== 1 || at_edge !== 5) begin
         n_err++;
         $display("FAIL overrun_pulse: got %0d pulses (last at edge k+%0d), want 1 at k+5", pulses, at_edge);
      end
      n_vec++;
      if (got !== exp_duty) begin
         n_err++;
         $display("FAIL overrun_duty: got %0d, want %0d", got, exp_duty);
      end
      n_vec++;
      if (bus.overrun !== 1'b1) begin
         n_err++;
         $display("FAIL overrun_set: got %b, want 1", bus.overrun);
      end
      run_sample(512, 507, "overrun_next");
      n_vec++;
      if (bus.overrun !== 1'b1) begin
         n_err++;
         $display("FAIL overrun_sticky: got %b, want 1", bus.overrun);
      end
   endtask

   task automatic test_enable_drop();
      int pulses;
      set_params(256, 0, 0, 100, 4095);
      run_sample(712, 512, "enable_pre");
      @(negedge hf_clock);
      bus.vref = 10'd600; bus.adc_sample = 10'd500; bus.sample_valid = 1'b1;
      @(posedge hf_clock);
      #1 bus.sample_valid = 1'b0;
      @(posedge hf_clock);
      #1 bus.enable = 1'b0;
      @(posedge hf_clock);
      #1;
      n_vec++;
      if (bus.duty_cycle !== 12'd100 || bus.busy !== 1'b0 || bus.duty_valid !== 1'b0) begin
         n_err++;
         $display("FAIL enable_drop: got duty=%0d busy=%b valid=%b, want 100/0/0",
                  bus.duty_cycle, bus.busy, bus.duty_valid);
      end
      @(negedge hf_clock);
      bus.sample_valid = 1'b1;
      @(posedge hf_clock);
      #1 bus.sample_valid = 1'b0;
      pulses = 0;
      repeat (6) begin
         @(posedge hf_clock);
         #1;
         if (bus.duty_valid || bus.busy) pulses++;
      end
      n_vec++;
      if (pulses !== 0 || bus.duty_cycle !== 12'd100) begin
         n_err++;
         $display("FAIL enable_low_ignore: got %0d active cycles duty=%0d, want 0 and 100",
                  pulses, bus.duty_cycle);
      end
      bus.enable = 1'b1;
      model_clear();
      run_sample(650, 500, "enable_fresh");
   endtask

   task automatic test_async_reset();
      @(negedge hf_clock);
      bus.vref = 10'd600; bus.adc_sample = 10'd500; bus.sample_valid = 1'b1;
      @(posedge hf_clock);
      #1 bus.sample_valid = 1'b0;
      repeat (3) @(posedge hf_clock);
      #2 reset = 1'b0;
      #1;
      n_vec++;
      if ({bus.duty_cycle, bus.duty_valid, bus.busy, bus.overrun} !== 15'd0) begin
         n_err++;
         $display("FAIL async_reset: got duty=%0d valid=%b busy=%b ovr=%b, want all 0",
                  bus.duty_cycle, bus.duty_valid, bus.busy, bus.overrun);
      end
      repeat (2) @(posedge hf_clock);
      @(negedge hf_clock);
      reset = 1'b1;
      repeat (4) @(posedge hf_clock);
      #1;
      model_clear();
      set_params(256, 0, 0, 0, 4095);
      run_sample(560, 500, "reset_fresh");
   endtask

   // Strobes exactly six edges apart: every one must be accepted, none flagged.
   task automatic test_back_to_back();
      int early, exp_duty, e;
      set_params(200, -64, 32, 0, 4095);
      clear_history();
      for (int i = 0; i < 5; i++) begin
         e = int'($urandom_range(0, 300));
         model_step(e, exp_duty);
         @(negedge hf_clock);
         bus.vref = 10'(400 + e); bus.adc_sample = 10'd400; bus.sample_valid = 1'b1;
         @(posedge hf_clock);
         #1 bus.sample_valid = 1'b0;
         early = 0;
         repeat (4) begin
            @(posedge hf_clock);
            #1;
            if (bus.duty_valid) early++;
         end
         @(posedge hf_clock);
         #1;
         n_vec++;
         if (bus.duty_valid !== 1'b1 || early !== 0 || bus.duty_cycle !== exp_duty[11:0]) begin
            n_err++;
            $display("FAIL back_to_back_%0d: got valid=%b early=%0d duty=%0d, want 1/0/%0d",
                     i, bus.duty_valid, early, bus.duty_cycle, exp_duty);
         end
      end
      n_vec++;
      if (bus.overrun !== 1'b0) begin
         n_err++;
         $display("FAIL back_to_back_overrun: got %b, want 0", bus.overrun);
      end
   endtask

   task automatic test_random();
      int v, a;
      for (int i = 0; i < 30; i++) begin
         set_params(int'($urandom_range(0, 1200)) - 600, int'($urandom_range(0, 1200)) - 600,
                    int'($urandom_range(0, 1200)) - 600, int'($urandom_range(0, 1500)),
                    int'($urandom_range(500, 4095)));
         if ($urandom_range(0, 7) == 0) clear_history();
         v = int'($urandom_range(0, 1023));
         a = int'($urandom_range(0, 1023));
         run_sample(v, a, $sformatf("random_%0d", i));
      end
   endtask

   initial begin
      bus.enable       = 1'b1;
      bus.sample_valid = 1'b0;
      bus.adc_sample   = '0;
      bus.vref         = '0;
      set_params(0, 0, 0, 0, 4095);
      model_clear();
      test_reset();
      test_integrator();
      test_delayed_tap();
      test_saturation();
      test_overrun();
      test_enable_drop();
      test_async_reset();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
